roll_button: RTL and testbench

Debounce and auto-repeat front end for the dice roller. It takes the raw, asynchronous ROLL push-button from the pad and produces one clean single-cycle ROLL pulse per press, with optional auto-repeat while the button is held. It also provides a debounced held level and a wrap-around roll counter. It sits directly upstream of the dice block and drives its ROLL input.

---
 rtl/roll_button_pkg.sv | 23 ++
 rtl/sync2.sv | 29 ++
 rtl/roll_button.sv | 133 +++++++++++++
 tb/tb_roll_button.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/roll_button_pkg.sv
// rtl/roll_button_pkg.sv - shared state encoding and helpers for the roll button front end
package roll_button_pkg;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_DB_PRESS   = 3'd1;
   localparam logic [2:0] ST_PRESSED    = 3'd2;
   localparam logic [2:0] ST_REPEAT     = 3'd3;
   localparam logic [2:0] ST_DB_RELEASE = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE       = ST_IDLE,
      S_DB_PRESS   = ST_DB_PRESS,
      S_PRESSED    = ST_PRESSED,
      S_REPEAT     = ST_REPEAT,
      S_DB_RELEASE = ST_DB_RELEASE
   } state_e;

   // The debounced level stays high until a release has been fully debounced.
   function automatic logic is_held(input state_e st);
      return (st == S_PRESSED) || (st == S_REPEAT) || (st == S_DB_RELEASE);
   endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for asynchronous pad inputs
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/roll_button.sv
// rtl/roll_button.sv - debounce and auto-repeat front end producing one ROLL pulse per press
module roll_button
   import roll_button_pkg::*;
#(
   parameter int CNT_W      = 20,
   parameter int DB_CYCLES  = 20000,
   parameter int RPT_DELAY  = 500000,
   parameter int RPT_PERIOD = 200000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN,
   input  logic       REPEAT_EN,
   output logic       ROLL,
   output logic       HELD,
   output logic [7:0] ROLL_COUNT
);

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             roll_d, roll_q;
   logic             held_d, held_q;
   logic [7:0]       count_d, count_q;
   logic             s;

   sync2 u_sync2 (
      .clk (CLK),
      .rst (RST),
      .d   (BTN),
      .q   (s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      roll_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (s) begin
               state_d = S_DB_PRESS;
               cnt_d   = '0;
            end
         end
         S_DB_PRESS: begin
            if (!s) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = S_PRESSED;
               cnt_d   = '0;
               roll_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_PRESSED: begin
            if (!s) begin
               state_d = S_DB_RELEASE;
               cnt_d   = '0;
            end else if (!REPEAT_EN) begin
               cnt_d = '0;
            end else if (cnt_q == DLY_LAST) begin
               // A terminal count right after a pulse waits one cycle so ROLL never stays high.
               if (!roll_q) begin
                  state_d = S_REPEAT;
                  cnt_d   = '0;
                  roll_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_REPEAT: begin
            if (!s) begin
               state_d = S_DB_RELEASE;
               cnt_d   = '0;
            end else if (REPEAT_EN) begin
               if (cnt_q == PER_LAST) begin
                  if (!roll_q) begin
                     cnt_d  = '0;
                     roll_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         S_DB_RELEASE: begin
            if (s) begin
               state_d = S_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      held_d  = is_held(state_d);
      count_d = count_q + {7'd0, roll_d};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         roll_q  <= 1'b0;
         held_q  <= 1'b0;
         count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         roll_q  <= roll_d;
         held_q  <= held_d;
         count_q <= count_d;
      end
   end

   assign ROLL       = roll_q;
   assign HELD       = held_q;
   assign ROLL_COUNT = count_q;

endmodule

// File: tb/tb_roll_button.sv
// tb/tb_roll_button.sv - self-checking bench for roll_button
module tb_roll_button;

   logic       CLK = 1'b0;
   logic       RST;
   logic       BTN;
   logic       REPEAT_EN;
   logic       ROLL;
   logic       HELD;
   logic [7:0] ROLL_COUNT;

   roll_button #(
      .CNT_W      (20),
      .DB_CYCLES  (4),
      .RPT_DELAY  (10),
      .RPT_PERIOD (5)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .BTN        (BTN),
      .REPEAT_EN  (REPEAT_EN),
      .ROLL       (ROLL),
      .HELD       (HELD),
      .ROLL_COUNT (ROLL_COUNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         cyc;
      logic [7:0] cnt;
   } pulse_t;

   typedef struct {
      logic       btn;
      logic       held;
      logic       roll;
      logic [7:0] cnt;
   } vec_t;

   pulse_t     sb[$];
   vec_t       tab[31];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_cnt = 8'd0;
   logic       roll_prev = 1'b0;
   logic       win_en = 1'b0;
   int         win_lo = 0;
   int         win_hi = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic push_pulse(input int c);
      exp_cnt = exp_cnt + 8'd1;
      sb.push_back('{cyc: c, cnt: exp_cnt});
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      exp_cnt = 8'd0;
      sb.delete();
      step(3);
      RST = 1'b0;
      step(2);
   endtask

   always @(negedge CLK) begin
      if (!RST) begin
         if (ROLL) begin
            pulse_t e;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_roll cyc=%0d got=1 want=0", cyc);
            end else begin
               e = sb.pop_front();
               if (e.cyc != cyc || e.cnt != ROLL_COUNT) begin
                  errors++;
                  $display("FAIL roll_pulse got cyc=%0d count=%0d want cyc=%0d count=%0d",
                           cyc, ROLL_COUNT, e.cyc, e.cnt);
               end
            end
            checks++;
            if (roll_prev) begin
               errors++;
               $display("FAIL roll_back_to_back cyc=%0d got=1 want=0", cyc);
            end
         end
         if (win_en) begin
            checks++;
            if (HELD !== ((cyc >= win_lo) && (cyc <= win_hi))) begin
               errors++;
               $display("FAIL held_window cyc=%0d got=%0b want=%0b", cyc, HELD,
                        ((cyc >= win_lo) && (cyc <= win_hi)));
            end
         end
      end
      roll_prev = ROLL;
   end

   initial begin
      int k;
      int t;

      RST = 1'b1;
      BTN = 1'b0;
      REPEAT_EN = 1'b0;
      step(3);
      chk("reset_roll", int'(ROLL), 0);
      chk("reset_held", int'(HELD), 0);
      chk("reset_count", int'(ROLL_COUNT), 0);
      RST = 1'b0;
      step(2);

      // Clean press (rows 0-9), release (10-19), bounce 1,0,1,1,0 (20-24), then quiet.
      for (int j = 0; j < 31; j++) begin
         tab[j].btn  = (j < 10) || (j == 20) || (j == 22) || (j == 23);
         tab[j].held = (j >= 6) && (j < 16);
         tab[j].roll = (j == 6);
         tab[j].cnt  = (j >= 6) ? 8'd1 : 8'd0;
      end
      k = cyc + 1;
      push_pulse(k + 6);
      for (int j = 0; j < 31; j++) begin
         BTN = tab[j].btn;
         @(posedge CLK);
         #1;
         chk($sformatf("tab_roll_%0d", j), int'(ROLL), int'(tab[j].roll));
         chk($sformatf("tab_held_%0d", j), int'(HELD), int'(tab[j].held));
         chk($sformatf("tab_count_%0d", j), int'(ROLL_COUNT), int'(tab[j].cnt));
      end

      // Auto-repeat; release lands exactly on a repeat terminal count (k+46).
      REPEAT_EN = 1'b1;
      k = cyc + 1;
      win_lo = k + 6;
      win_hi = k + 49;
      win_en = 1'b1;
      push_pulse(k + 6);
      t = k + 16;
      while (t < k + 46) begin
         push_pulse(t);
         t += 5;
      end
      BTN = 1'b1;
      step(44);
      BTN = 1'b0;
      step(14);
      win_en = 1'b0;
      chk("repeat_count", int'(ROLL_COUNT), int'(exp_cnt));

      // Release glitch of two cycles restarts the repeat delay.
      k = cyc + 1;
      win_lo = k + 6;
      win_hi = k + 35;
      win_en = 1'b1;
      push_pulse(k + 6);
      push_pulse(k + 24);
      push_pulse(k + 29);
      BTN = 1'b1;
      step(10);
      BTN = 1'b0;
      step(2);
      BTN = 1'b1;
      step(18);
      BTN = 1'b0;
      step(12);
      win_en = 1'b0;
      chk("glitch_count", int'(ROLL_COUNT), int'(exp_cnt));

      // 256 presses wrap the counter back to zero.
      do_reset();
      REPEAT_EN = 1'b0;
      for (int i = 0; i < 256; i++) begin
         k = cyc + 1;
         push_pulse(k + 6);
         BTN = 1'b1;
         step(8);
         BTN = 1'b0;
         step(8);
      end
      chk("wrap_count", int'(ROLL_COUNT), 0);
      k = cyc + 1;
      push_pulse(k + 6);
      BTN = 1'b1;
      step(8);
      BTN = 1'b0;
      step(8);
      chk("post_wrap_count", int'(ROLL_COUNT), 1);

      // Asynchronous reset while debouncing a press, button still held afterwards.
      BTN = 1'b1;
      step(4);
      RST = 1'b1;
      #1;
      chk("async_rst_roll", int'(ROLL), 0);
      chk("async_rst_held", int'(HELD), 0);
      chk("async_rst_count", int'(ROLL_COUNT), 0);
      exp_cnt = 8'd0;
      sb.delete();
      step(3);
      RST = 1'b0;
      k = cyc + 1;
      push_pulse(k + 6);
      step(5);
      chk("rst_no_early_pulse_count", int'(ROLL_COUNT), 0);
      step(7);
      chk("rst_redebounce_held", int'(HELD), 1);
      chk("rst_redebounce_count", int'(ROLL_COUNT), 1);
      BTN = 1'b0;
      step(12);
      chk("rst_release_held", int'(HELD), 0);

      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
